// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : rcpu_defs                                                        |
// | Brief   : Shared word width, load/store sequencer state encoding and the   |
// |           register-index one-hot decode helper.                            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package rcpu_defs;

    localparam int WORD_WIDTH  = 16;
    localparam int TIMER_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WB   = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

    // Indices of 32 or more decode to all zero; callers truncate the result to
    // their register count, so any index beyond that count also yields zero.
    function automatic logic [31:0] reg_onehot(input logic [31:0] idx);
        logic [31:0] v;
        v = '0;
        if (idx < 32'd32) begin
            v[idx[4:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : load_store_unit_if                                             |
// | Brief     : req/ack memory bus between the load/store sequencer (master)   |
// |             and the memory (slave). Read data is valid with mem_ack.       |
// | Rev       : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface load_store_unit_if #(
    parameter int WORD_WIDTH = 16
);
    logic [WORD_WIDTH-1:0] mem_addr;
    logic [WORD_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic                  mem_req;
    logic                  mem_ack;
    logic [WORD_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        output mem_req,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        input  mem_req,
        output mem_ack,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit_ack_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ack_timer                                                         |
// | Brief  : 8-bit wait counter for the memory handshake. Flags expiry when   |
// |          the count equals TIMEOUT; TIMEOUT = 0 never expires. TIMEOUT     |
// |          must lie in 0..255.                                               |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module ack_timer
    import rcpu_defs::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [TIMER_WIDTH-1:0] c_limit = TIMER_WIDTH'(TIMEOUT);
    localparam logic [TIMER_WIDTH-1:0] c_one   = TIMER_WIDTH'(1);

    logic [TIMER_WIDTH-1:0] r_count;

    // Wait counter: clear has priority over counting.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + c_one;
        end
    end

    assign o_expired = (r_count == c_limit) && (TIMEOUT != 0);

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : load_store_unit                                                   |
// | Brief  : Multi-cycle load/store sequencer feeding the register bank.       |
// |          IDLE -> REQ -> WB (load) / DONE (store) -> IDLE, with a bounded  |
// |          wait in REQ that aborts back to IDLE with an error pulse.        |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module load_store_unit #(
    parameter int WORD_WIDTH = rcpu_defs::WORD_WIDTH,
    parameter int REG_COUNT  = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         is_store,
    input  logic [WORD_WIDTH-1:0]        addr,
    input  logic [WORD_WIDTH-1:0]        store_data,
    input  logic [$clog2(REG_COUNT)-1:0] dest_sel,
    load_store_unit_if.master            mem,
    output logic [WORD_WIDTH-1:0]        reg_in,
    output logic [REG_COUNT-1:0]         reg_en,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);
    import rcpu_defs::*;

    localparam int c_dest_w = $clog2(REG_COUNT);

    lsu_state_e              r_state;
    lsu_state_e              w_next_state;
    logic                    r_is_store;
    logic [c_dest_w-1:0]     r_dest;
    logic [WORD_WIDTH-1:0]   r_mem_addr;
    logic [WORD_WIDTH-1:0]   r_mem_wdata;
    logic [WORD_WIDTH-1:0]   r_reg_in;
    logic                    r_error;
    logic                    w_accept;
    logic                    w_capture;
    logic                    w_timeout;
    logic                    w_timer_clear;
    logic                    w_timer_en;
    logic                    w_expired;

    ack_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_ack_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_timer_clear),
        .i_enable  (w_timer_en),
        .o_expired (w_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic plus the strobes that steer the datapath and timer.
    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        w_capture     = 1'b0;
        w_timeout     = 1'b0;
        w_timer_clear = 1'b0;
        w_timer_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept      = 1'b1;
                    w_timer_clear = 1'b1;
                    w_next_state  = S_REQ;
                end
            end
            S_REQ: begin
                if (mem.mem_ack) begin
                    w_capture    = ~r_is_store;
                    w_next_state = r_is_store ? S_DONE : S_WB;
                end else if (w_expired) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    w_timer_en = 1'b1;
                end
            end
            S_WB:    w_next_state = S_IDLE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Request latch, load-data capture and the registered timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_store  <= 1'b0;
            r_dest      <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_reg_in    <= '0;
            r_error     <= 1'b0;
        end else begin
            r_error <= w_timeout;
            if (w_accept) begin
                r_is_store  <= is_store;
                r_dest      <= dest_sel;
                r_mem_addr  <= addr;
                r_mem_wdata <= store_data;
            end
            if (w_capture) begin
                r_reg_in <= mem.mem_rdata;
            end
        end
    end

    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign mem.mem_req   = (r_state == S_REQ);
    assign mem.mem_we    = (r_state == S_REQ) && r_is_store;

    assign reg_in = r_reg_in;
    // Out-of-range destinations decode above REG_COUNT and truncate to zero.
    assign reg_en = (r_state == S_WB) ? REG_COUNT'(reg_onehot(32'(r_dest))) : '0;
    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_WB) || (r_state == S_DONE);
    assign error  = r_error;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_load_store_unit                                                |
// | Brief  : Self-checking bench: directed scenarios plus randomized          |
// |          transactions checked against a transaction-level model.          |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_load_store_unit;

    localparam int WW = 16;
    localparam int RC = 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          is_store;
    logic [WW-1:0] addr;
    logic [WW-1:0] store_data;
    logic [2:0]    dest_sel;
    logic [WW-1:0] reg_in;
    logic [RC-1:0] reg_en;
    logic          busy;
    logic          done;
    logic          error;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: last word written toward the register bank, and memory contents.
    logic [WW-1:0] last_reg_in;
    logic [WW-1:0] mem_model [logic [WW-1:0]];

    load_store_unit_if #(.WORD_WIDTH(WW)) bus ();

    load_store_unit #(
        .WORD_WIDTH (WW),
        .REG_COUNT  (RC),
        .TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_store   (is_store),
        .addr       (addr),
        .store_data (store_data),
        .dest_sel   (dest_sel),
        .mem        (bus),
        .reg_in     (reg_in),
        .reg_en     (reg_en),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction, started in the current (IDLE) cycle. delay = number of
    // REQ cycles the memory waits before acking; delay < 0 means never ack.
    // Returns in the first IDLE cycle after completion.
    task automatic run_txn(input logic st, input logic [WW-1:0] a, input logic [WW-1:0] wd,
                           input logic [2:0] ds, input int delay, input bit spam,
                           input logic [WW-1:0] rd);
        int            cyc = 0;
        int            req_n = 0;
        int            busy_n = 0;
        int            done_n = 0;
        int            err_n = 0;
        int            wr_n = 0;
        int            first_req = -1;
        int            done_at = -1;
        int            err_at = -1;
        logic [RC-1:0] wr_en = '0;
        logic [WW-1:0] wr_data = '0;
        logic [RC-1:0] exp_en;
        bit            never_ack;
        never_ack   = (delay < 0);
        start       = 1'b1;
        is_store    = st;
        addr        = a;
        store_data  = wd;
        dest_sel    = ds;
        bus.mem_ack = 1'b0;
        while (1) begin
            @(posedge clk);
            #1;
            cyc++;
            if (spam) begin
                start      = 1'b1;
                is_store   = 1'($urandom);
                addr       = 16'($urandom);
                store_data = 16'($urandom);
                dest_sel   = 3'($urandom);
            end else begin
                start = 1'b0;
            end
            bus.mem_rdata = 16'($urandom);
            bus.mem_ack   = 1'b0;
            if (bus.mem_req) begin
                if (first_req < 0) first_req = cyc;
                check_val("mem_addr", 32'(bus.mem_addr), 32'(a));
                check_val("mem_we", 32'(bus.mem_we), 32'(st));
                if (st) check_val("mem_wdata", 32'(bus.mem_wdata), 32'(wd));
                check_val("req_quiet", 32'({reg_en, done, error}), 32'(0));
                if (!never_ack && req_n == delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rd;
                end
                req_n++;
            end else begin
                bus.mem_ack = 1'($urandom);
            end
            if (busy) busy_n++;
            if (reg_en != '0) begin
                wr_n++;
                wr_en   = reg_en;
                wr_data = reg_in;
            end
            if (done) begin
                done_n++;
                done_at = cyc;
            end
            if (error) begin
                err_n++;
                err_at = cyc;
            end
            if (!busy) begin
                start = 1'b0;
                break;
            end
            if (cyc > 400) begin
                check_val("txn_cycle_bound", 32'(cyc), 32'(0));
                start = 1'b0;
                break;
            end
        end
        check_val("first_req_cycle", 32'(first_req), 32'(1));
        if (never_ack) begin
            check_val("to_req_cycles", 32'(req_n), 32'(TO + 1));
            check_val("to_error_count", 32'(err_n), 32'(1));
            check_val("to_error_cycle", 32'(err_at), 32'(TO + 2));
            check_val("to_done_count", 32'(done_n), 32'(0));
            check_val("to_write_count", 32'(wr_n), 32'(0));
            check_val("to_busy_cycles", 32'(busy_n), 32'(TO + 1));
        end else begin
            check_val("req_cycles", 32'(req_n), 32'(delay + 1));
            check_val("done_count", 32'(done_n), 32'(1));
            check_val("done_cycle", 32'(done_at), 32'(delay + 2));
            check_val("error_count", 32'(err_n), 32'(0));
            check_val("busy_cycles", 32'(busy_n), 32'(delay + 2));
            if (!st) begin
                exp_en = RC'(1) << ds;
                check_val("write_count", 32'(wr_n), 32'(1));
                check_val("write_enable", 32'(wr_en), 32'(exp_en));
                check_val("write_data", 32'(wr_data), 32'(rd));
                last_reg_in = rd;
            end else begin
                check_val("store_write_count", 32'(wr_n), 32'(0));
            end
        end
        check_val("reg_in_hold", 32'(reg_in), 32'(last_reg_in));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic          st;
        logic [WW-1:0] a;
        logic [WW-1:0] wd;
        logic [WW-1:0] rd;
        int            dly;
        int            gap;

        rst           = 1'b1;
        start         = 1'b0;
        is_store      = 1'b0;
        addr          = '0;
        store_data    = '0;
        dest_sel      = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        last_reg_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_mem_req", 32'(bus.mem_req), 32'(0));
        check_val("rst_mem_we", 32'(bus.mem_we), 32'(0));
        check_val("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
        check_val("rst_mem_wdata", 32'(bus.mem_wdata), 32'(0));
        check_val("rst_flags", 32'({busy, done, error}), 32'(0));
        check_val("rst_reg_en", 32'(reg_en), 32'(0));
        check_val("rst_reg_in", 32'(reg_in), 32'(0));
        rst = 1'b0;

        // Directed load, ack after two wait cycles.
        run_txn(1'b0, 16'h0040, 16'h0000, 3'd3, 2, 1'b0, 16'h1234);
        // Directed store, immediate ack.
        run_txn(1'b1, 16'h00A0, 16'h5678, 3'd2, 0, 1'b0, 16'h0000);
        // Start held high through a busy load: must not be re-latched or queued.
        run_txn(1'b0, 16'h0123, 16'h0000, 3'd6, 3, 1'b1, 16'h4321);
        @(posedge clk);
        #1;
        check_val("no_queued_start", 32'({busy, bus.mem_req}), 32'(0));
        // Dead memory: timeout abort.
        run_txn(1'b0, 16'h0777, 16'h0000, 3'd5, -1, 1'b0, 16'h0000);
        // Ack arriving exactly in the cycle the timer expires wins.
        run_txn(1'b0, 16'h0778, 16'h0000, 3'd4, TO, 1'b0, 16'hBEEF);

        // Reset raised while waiting in REQ.
        start      = 1'b1;
        is_store   = 1'b0;
        addr       = 16'h0300;
        dest_sel   = 3'd2;
        bus.mem_ack = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val("pre_rst_req", 32'(bus.mem_req), 32'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("midrst_mem_req", 32'(bus.mem_req), 32'(0));
        check_val("midrst_busy", 32'(busy), 32'(0));
        check_val("midrst_reg_en", 32'(reg_en), 32'(0));
        check_val("midrst_done_err", 32'({done, error}), 32'(0));
        check_val("midrst_reg_in", 32'(reg_in), 32'(0));
        rst = 1'b0;
        last_reg_in = '0;
        run_txn(1'b0, 16'h0050, 16'h0000, 3'd0, 1, 1'b0, 16'h9ABC);

        // Back-to-back loads: second starts in the first IDLE cycle.
        run_txn(1'b0, 16'h0060, 16'h0000, 3'd1, 0, 1'b0, 16'hDEF0);
        run_txn(1'b0, 16'h0061, 16'h0000, 3'd7, 2, 1'b0, 16'h0F0F);

        // Randomized traffic against the memory model.
        for (int i = 0; i < 60; i++) begin
            st  = 1'($urandom);
            a   = 16'($urandom_range(0, 15));
            wd  = 16'($urandom);
            dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TO));
            if (mem_model.exists(a)) begin
                rd = mem_model[a];
            end else begin
                rd = 16'($urandom);
                mem_model[a] = rd;
            end
            run_txn(st, a, wd, 3'($urandom), dly, bit'($urandom_range(0, 3) == 0), rd);
            if (st && dly >= 0) mem_model[a] = wd;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
                bus.mem_ack = 1'($urandom);
                check_val("idle_busy", 32'(busy), 32'(0));
            end
            bus.mem_ack = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
